dep_mult_rand_feeder: RTL and testbench
=======================================

Name: dep_mult_rand_feeder

Overview:
- Input stage directly upstream of the DOM-dependent GF(2^2) multiplier in the masked AES S-box.
- Accepts two-share operands x and y through a valid/ready handshake.
- Registers the operands and attaches fresh randomness: blinding shares Az/Bz and the remasking bit pair Z, taken from an internal seeded LFSR.
- Tracks a result-valid flag that is aligned to the multiplier's register stage.

Parameters:
- SEED_W, 32, LFSR width; the polynomial is fixed for 32 bits.
- WARMUP_CYCLES, 8, LFSR clock cycles after a seed load before operands are accepted.
- MULT_LATENCY, 1, register stages in the downstream multiplier; sets the res_valid delay.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- seed_load  in  1  pulse: load seed and restart warm-up.
- seed  in  SEED_W  LFSR seed value.
- in_valid  in  1  operand pair presented.
- in_ready  out  1  feeder accepts operands this cycle.
- x0, x1  in  2 each  shares of operand x.
- y0, y1  in  2 each  shares of operand y.
- Ax, Bx  out  2 each  registered shares of x.
- Ay, By  out  2 each  registered shares of y.
- Az, Bz  out  2 each  fresh blinding shares.
- Z  out  2  fresh remask value.
- mult_valid  out  1  multiplier inputs valid this cycle.
- res_valid  out  1  multiplier outputs Aq/Bq valid this cycle.

Behaviour:
- Reset (rst=1 at an edge):
  - state=UNSEEDED; lfsr=32'h1; warm-up counter=0.
  - All data outputs = 0; in_ready=0; mult_valid=0; res_valid pipeline cleared.
- LFSR:
  - Fibonacci, taps x^32+x^22+x^2+x+1.
  - Advances 6 bit-steps per clock (unrolled) in WARMUP and READY; held in UNSEEDED.
- State machine:
  - UNSEEDED: in_ready=0. seed_load -> WARMUP.
  - WARMUP: in_ready=0; counter increments each cycle. Counter=WARMUP_CYCLES-1 -> READY.
  - READY: in_ready=1 combinationally. Stays in READY until seed_load or rst.
- seed_load, any state:
  - lfsr<=seed; seed=0 loads 32'h1 (all-zero lock-up is forbidden).
  - Counter<=0; state<=WARMUP.
  - mult_valid and the res_valid pipeline are cleared in the same edge, so in-flight results are dropped.
  - seed_load has priority over a simultaneous handshake; that operand is not accepted.
- Handshake: a transfer occurs when in_valid & in_ready are high at an edge. At that edge:
  - Ax<=x0, Bx<=x1, Ay<=y0, By<=y1.
  - Az<=lfsr[1:0], Bz<=lfsr[3:2], Z<=lfsr[5:4], using the pre-advance LFSR value.
  - mult_valid<=1.
- No transfer at an edge: mult_valid<=0; data outputs hold their previous values. They are not zeroed, to avoid extra share-combining glitches.
- Latency:
  - Operand to mult_valid: 1 cycle.
  - res_valid = mult_valid delayed by MULT_LATENCY cycles through a shift register.
- Throughput: one operand pair per cycle in READY; no backpressure from downstream (the multiplier is fully pipelined).
- Randomness use: each accepted operation consumes 6 LFSR bits that are not shared with any other operation, because the LFSR advances 6 steps every cycle.
- Security rules:
  - Share x0 must never be combined with x1 in any logic.
  - Same for y0/y1.
  - Each output is driven directly by its own register.

Optional Feature:
- Macro: DEP_FEEDER_RAND_OFF_EN, for functional debug only.
- Defined:
  - Adds input port rand_off (1 bit).
  - When rand_off=1 at a transfer, Az, Bz and Z are captured as 2'b00; the LFSR still advances.
  - rand_off=0 behaves normally.
- Undefined: no port; randomness is always applied.

Test Plan:
- Reset, then no seed_load for 20 cycles -> in_ready=0, mult_valid=0, all outputs 0.
- seed_load with seed=32'hACE1, then wait -> in_ready=0 for exactly 8 cycles, rises in cycle 9.
- In READY, x0=01, x1=10, y0=11, y1=00 for one cycle:
  - Next cycle: Ax=01, Bx=10, Ay=11, By=00, mult_valid=1.
  - Az/Bz/Z match the bits of a reference LFSR model.
  - res_valid=1 one cycle later.
  - With the multiplier attached, Aq^Bq = GF(2^2) product 11*11 = 10.
- Back-to-back stream of 16 random operand pairs -> mult_valid high 16 consecutive cycles; no two transfers receive the same 6-bit LFSR window; every Aq^Bq equals x*y.
- seed_load asserted in the same cycle as in_valid, with a result in flight -> operand rejected, mult_valid=0 and res_valid=0 next cycle, warm-up restarts.
- seed=0 load -> LFSR behaves as seed 32'h1. With DEP_FEEDER_RAND_OFF_EN and rand_off=1 -> Az=Bz=Z=00 on the transfer.

Source files
------------

// File: rtl/dep_mult_rand_feeder.sv
// dep_mult_rand_feeder
//   Operand/randomness input stage for the DOM-dependent GF(2^2) multiplier
//   of the masked AES S-box. Registers the two-share operands x and y and
//   attaches fresh blinding shares (Az, Bz) and a remask pair (Z) drawn
//   from an internal seeded 32-bit Fibonacci LFSR (x^32+x^22+x^2+x+1) that
//   advances six bit-steps per clock, so each accepted operation sees six
//   LFSR bits never used by any other operation.
//
//   Optional build macro: DEP_FEEDER_RAND_OFF_EN
//     Adds input rand_off; when high at a transfer Az/Bz/Z are captured as
//     zero (functional debug only). The LFSR keeps advancing regardless.
//
//   Share hygiene: x0 never meets x1 (nor y0 meets y1) in any logic cone,
//   and every data output comes straight from its own flop.

module dep_mult_rand_feeder #(
   parameter int SEED_W        = 32,  // tap positions below assume 32
   parameter int WARMUP_CYCLES = 8,
   parameter int MULT_LATENCY  = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              seed_load,
   input  logic [SEED_W-1:0] seed,
`ifdef DEP_FEEDER_RAND_OFF_EN
   input  logic              rand_off,
`endif
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        x0,
   input  logic [1:0]        x1,
   input  logic [1:0]        y0,
   input  logic [1:0]        y1,
   output logic [1:0]        Ax,
   output logic [1:0]        Bx,
   output logic [1:0]        Ay,
   output logic [1:0]        By,
   output logic [1:0]        Az,
   output logic [1:0]        Bz,
   output logic [1:0]        Z,
   output logic              mult_valid,
   output logic              res_valid
);

   localparam int                CNT_W    = $clog2(WARMUP_CYCLES + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WARMUP_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_UNSEEDED = 2'd0,
      ST_WARMUP   = 2'd1,
      ST_READY    = 2'd2
   } state_e;

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [SEED_W-1:0]    lfsr_q, lfsr_d;

   logic [1:0]           ax_q, bx_q, ay_q, by_q;
   logic [1:0]           az_q, bz_q, z_q;
   logic                 mult_valid_q;
   logic [MULT_LATENCY-1:0] res_pipe_q;

   logic                 xfer;
   logic                 rand_en;

   // Six unrolled Fibonacci steps; the new bit enters at bit 0.
   function automatic logic [SEED_W-1:0] lfsr_adv6(input logic [SEED_W-1:0] v);
      logic [SEED_W-1:0] s;
      // NOTE: blocking assignments inside functions/always_comb model
      // combinational chains; flops below use non-blocking only.
      s = v;
      for (int i = 0; i < 6; i++) begin
         s = {s[SEED_W-2:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
      end
      return s;
   endfunction

`ifdef DEP_FEEDER_RAND_OFF_EN
   assign rand_en = ~rand_off;
`else
   assign rand_en = 1'b1;
`endif

   // A seed load always wins over a simultaneous operand.
   assign xfer = in_valid & in_ready & ~seed_load;

   // Next-state logic for the seeding FSM, warm-up counter and LFSR.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it
      // unassigned, which would otherwise infer a latch.
      state_d  = state_q;
      cnt_d    = cnt_q;
      lfsr_d   = lfsr_q;
      in_ready = (state_q == ST_READY);

      case (state_q)
         ST_WARMUP: begin
            cnt_d  = cnt_q + CNT_W'(1);
            lfsr_d = lfsr_adv6(lfsr_q);
            if (cnt_q == CNT_LAST) begin
               state_d = ST_READY;
               cnt_d   = '0;
            end
         end
         ST_READY: begin
            lfsr_d = lfsr_adv6(lfsr_q);
         end
         default: begin
            // ST_UNSEEDED: LFSR held until a seed arrives.
         end
      endcase

      if (seed_load) begin
         // All-zero is the LFSR lock-up state, so substitute 1.
         lfsr_d  = (seed == '0) ? SEED_W'(1) : seed;
         cnt_d   = '0;
         state_d = ST_WARMUP;
      end
   end

   // Control state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_UNSEEDED;
         cnt_q   <= '0;
         lfsr_q  <= SEED_W'(1);
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         lfsr_q  <= lfsr_d;
      end
   end

   // Operand and randomness capture; values hold between transfers so
   // shares are not disturbed with extra toggles.
   always_ff @(posedge clk) begin
      if (rst) begin
         ax_q <= '0;
         bx_q <= '0;
         ay_q <= '0;
         by_q <= '0;
         az_q <= '0;
         bz_q <= '0;
         z_q  <= '0;
      end else if (xfer) begin
         ax_q <= x0;
         bx_q <= x1;
         ay_q <= y0;
         by_q <= y1;
         az_q <= lfsr_q[1:0] & {2{rand_en}};
         bz_q <= lfsr_q[3:2] & {2{rand_en}};
         z_q  <= lfsr_q[5:4] & {2{rand_en}};
      end
   end

   // Valid tracking aligned to the multiplier pipeline; a seed load
   // drops everything in flight.
   always_ff @(posedge clk) begin
      if (rst || seed_load) begin
         mult_valid_q <= 1'b0;
         res_pipe_q   <= '0;
      end else begin
         mult_valid_q  <= xfer;
         res_pipe_q[0] <= mult_valid_q;
         for (int i = 1; i < MULT_LATENCY; i++) begin
            res_pipe_q[i] <= res_pipe_q[i-1];
         end
      end
   end

   assign Ax         = ax_q;
   assign Bx         = bx_q;
   assign Ay         = ay_q;
   assign By         = by_q;
   assign Az         = az_q;
   assign Bz         = bz_q;
   assign Z          = z_q;
   assign mult_valid = mult_valid_q;
   assign res_valid  = res_pipe_q[MULT_LATENCY-1];

endmodule

// File: tb/tb_dep_mult_rand_feeder.sv
// Testbench for dep_mult_rand_feeder: directed stimulus pushes expected
// captures into a scoreboard queue; a monitor pops and compares whenever
// mult_valid is seen. Product checks use the GF(2^2) polynomial basis
// (w^2 = w + 1). Define DEP_FEEDER_RAND_OFF_EN to exercise rand_off.

module tb_dep_mult_rand_feeder;

   logic        clk;
   logic        rst;
   logic        seed_load;
   logic [31:0] seed;
`ifdef DEP_FEEDER_RAND_OFF_EN
   logic        rand_off;
`endif
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  x0, x1, y0, y1;
   logic [1:0]  Ax, Bx, Ay, By, Az, Bz, Z;
   logic        mult_valid;
   logic        res_valid;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [1:0] ax, bx, ay, by, az, bz, z, prod;
   } exp_t;

   exp_t        sb_q[$];
   exp_t        mon_e;

   logic [31:0] m_lfsr;
   logic        m_run;

   dep_mult_rand_feeder dut (
      .clk        (clk),
      .rst        (rst),
      .seed_load  (seed_load),
      .seed       (seed),
`ifdef DEP_FEEDER_RAND_OFF_EN
      .rand_off   (rand_off),
`endif
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .x0         (x0),
      .x1         (x1),
      .y0         (y0),
      .y1         (y1),
      .Ax         (Ax),
      .Bx         (Bx),
      .Ay         (Ay),
      .By         (By),
      .Az         (Az),
      .Bz         (Bz),
      .Z          (Z),
      .mult_valid (mult_valid),
      .res_valid  (res_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // GF(2^2) multiply, basis {1, w}, w^2 = w + 1.
   function automatic logic [1:0] gf_mul(input logic [1:0] a, input logic [1:0] b);
      if (a == 2'd0 || b == 2'd0) return 2'd0;
      if (a == 2'd1) return b;
      if (b == 2'd1) return a;
      if (a == b) return (a == 2'd2) ? 2'd3 : 2'd2;
      return 2'd1;
   endfunction

   // Reference LFSR step: feedback is the parity of taps 32,22,2,1.
   function automatic logic [31:0] model_adv6(input logic [31:0] v);
      logic [31:0] s;
      s = v;
      repeat (6) s = {s[30:0], ^(s & 32'h8020_0003)};
      return s;
   endfunction

   // Reference LFSR, free-running once seeded.
   always @(posedge clk) begin
      if (rst) begin
         m_lfsr <= 32'h1;
         m_run  <= 1'b0;
      end else if (seed_load) begin
         m_lfsr <= (seed == 32'h0) ? 32'h1 : seed;
         m_run  <= 1'b1;
      end else if (m_run) begin
         m_lfsr <= model_adv6(m_lfsr);
      end
   end

   // Monitor: every mult_valid cycle must match the oldest expectation.
   always @(negedge clk) begin
      if (!rst && mult_valid) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_mult_valid: got 1 expected 0 at %0t", $time);
         end else begin
            mon_e = sb_q.pop_front();
            check("Ax", 32'(Ax), 32'(mon_e.ax));
            check("Bx", 32'(Bx), 32'(mon_e.bx));
            check("Ay", 32'(Ay), 32'(mon_e.ay));
            check("By", 32'(By), 32'(mon_e.by));
            check("Az", 32'(Az), 32'(mon_e.az));
            check("Bz", 32'(Bz), 32'(mon_e.bz));
            check("Z",  32'(Z),  32'(mon_e.z));
            check("prod", 32'(gf_mul(Ax ^ Bx, Ay ^ By)), 32'(mon_e.prod));
         end
      end
   end

   task automatic push_exp(input logic [1:0] ax, input logic [1:0] bx,
                           input logic [1:0] ay, input logic [1:0] by,
                           input logic [1:0] az, input logic [1:0] bz,
                           input logic [1:0] z,  input logic [1:0] prod);
      exp_t e;
      e.ax = ax; e.bx = bx; e.ay = ay; e.by = by;
      e.az = az; e.bz = bz; e.z = z; e.prod = prod;
      sb_q.push_back(e);
   endtask

   // Drive one operand pair (called at a negedge).
   task automatic drive(input logic [1:0] a0, input logic [1:0] a1,
                        input logic [1:0] b0, input logic [1:0] b1);
      in_valid = 1'b1;
      x0 = a0; x1 = a1; y0 = b0; y1 = b1;
   endtask

   logic [1:0] r0, r1, r2, r3;

   initial begin
      rst = 1'b1; seed_load = 1'b0; seed = 32'h0; in_valid = 1'b0;
      x0 = 2'd0; x1 = 2'd0; y0 = 2'd0; y1 = 2'd0;
`ifdef DEP_FEEDER_RAND_OFF_EN
      rand_off = 1'b0;
`endif
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Unseeded: nothing accepted, all outputs zero.
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("unseeded_in_ready", 32'(in_ready), 32'd0);
         check("unseeded_mult_valid", 32'(mult_valid), 32'd0);
         check("unseeded_res_valid", 32'(res_valid), 32'd0);
         check("unseeded_outputs", 32'({Ax, Bx, Ay, By, Az, Bz, Z}), 32'd0);
      end

      // Seed and warm-up: in_ready low for exactly 8 cycles.
      seed = 32'hACE1; seed_load = 1'b1;
      @(negedge clk);
      seed_load = 1'b0;
      for (int i = 0; i < 8; i++) begin
         check("warmup_in_ready", 32'(in_ready), 32'd0);
         @(negedge clk);
      end
      check("ready_rise", 32'(in_ready), 32'd1);

      // Directed transfer: x = 01^10 = 11, y = 11^00 = 11, product 10.
      drive(2'b01, 2'b10, 2'b11, 2'b00);
      push_exp(2'b01, 2'b10, 2'b11, 2'b00, m_lfsr[1:0], m_lfsr[3:2], m_lfsr[5:4], 2'b10);
      @(negedge clk);
      in_valid = 1'b0;
      check("dir_mult_valid", 32'(mult_valid), 32'd1);
      check("dir_res_valid_early", 32'(res_valid), 32'd0);
      @(negedge clk);
      check("dir_mult_valid_drop", 32'(mult_valid), 32'd0);
      check("dir_res_valid", 32'(res_valid), 32'd1);
      check("dir_hold_Ax", 32'(Ax), 32'(2'b01));
      check("dir_hold_Ay", 32'(Ay), 32'(2'b11));

      // Back-to-back stream of 16 pairs.
      for (int i = 0; i < 16; i++) begin
         r0 = 2'($urandom); r1 = 2'($urandom); r2 = 2'($urandom); r3 = 2'($urandom);
         drive(r0, r1, r2, r3);
         push_exp(r0, r1, r2, r3, m_lfsr[1:0], m_lfsr[3:2], m_lfsr[5:4],
                  gf_mul(r0 ^ r1, r2 ^ r3));
         @(negedge clk);
         check("stream_mult_valid", 32'(mult_valid), 32'd1);
         check("stream_in_ready", 32'(in_ready), 32'd1);
      end
      in_valid = 1'b0;
      @(negedge clk);
      check("stream_end_mult_valid", 32'(mult_valid), 32'd0);
      check("stream_end_res_valid", 32'(res_valid), 32'd1);

      // In-flight result, then seed_load (seed 0) with a competing operand.
      // x = 10^01 = 11, y = 01^11 = 10, product 01.
      drive(2'b10, 2'b01, 2'b01, 2'b11);
      push_exp(2'b10, 2'b01, 2'b01, 2'b11, m_lfsr[1:0], m_lfsr[3:2], m_lfsr[5:4], 2'b01);
      @(negedge clk);
      drive(2'b11, 2'b11, 2'b10, 2'b10);
      seed = 32'h0; seed_load = 1'b1;
      @(negedge clk);
      seed_load = 1'b0; in_valid = 1'b0;
      check("seedld_mult_valid", 32'(mult_valid), 32'd0);
      check("seedld_res_valid", 32'(res_valid), 32'd0);
      check("seedld_in_ready", 32'(in_ready), 32'd0);
      check("seedld_hold_Ax", 32'(Ax), 32'(2'b10));
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         check("rewarm_in_ready", 32'(in_ready), 32'd0);
      end
      @(negedge clk);
      check("rewarm_ready_rise", 32'(in_ready), 32'd1);

      // First transfer after seed 0 (behaves as seed 1): the pre-advance
      // LFSR is 48 steps past 32'h1, low six bits 100001.
      // x = 11, y = 10, product 01.
      drive(2'b11, 2'b00, 2'b10, 2'b00);
      push_exp(2'b11, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b01);
      @(negedge clk);
      in_valid = 1'b0;

`ifdef DEP_FEEDER_RAND_OFF_EN
      // Randomness disabled: blinding and remask captured as zero.
      rand_off = 1'b1;
      drive(2'b01, 2'b00, 2'b11, 2'b10);
      push_exp(2'b01, 2'b00, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01);
      @(negedge clk);
      in_valid = 1'b0;
      rand_off = 1'b0;
`endif

      repeat (3) @(negedge clk);
      check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
